wm8731_init_seq: RTL and testbench



---
 rtl/wm8731_pkg.sv | 25 ++
 rtl/wm8731_init_seq.sv | 160 ++++++++++++++++
 tb/tb_wm8731_init_seq.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wm8731_pkg.sv
// WM8731 codec configuration constants shared by the init sequencer.
// Holds the register word ROM and the sequencer state encoding.
package wm8731_pkg;

  localparam logic [7:0] WM8731_ADDR = 8'h34;
  localparam int         CFG_DEPTH   = 7;

  // reset, analog, digital, power, format, sampling, active
  localparam logic [23:0] CFG_ROM [CFG_DEPTH] = '{
    {WM8731_ADDR, 16'h1E00},
    {WM8731_ADDR, 16'h0815},
    {WM8731_ADDR, 16'h0A00},
    {WM8731_ADDR, 16'h0C00},
    {WM8731_ADDR, 16'h0E42},
    {WM8731_ADDR, 16'h1019},
    {WM8731_ADDR, 16'h1201}
  };

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    GAP
  } state_e;

endpackage

// File: rtl/wm8731_init_seq.sv
// Issues the WM8731 power-up word list to the I2C sender, one per transaction.
// WM_INIT_TIMEOUT_EN adds a per-transaction watchdog and the o_error port.
module wm8731_init_seq
  import wm8731_pkg::*;
#(
  parameter int N_CMD          = 7,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_i2c_finished,
  output logic        o_i2c_start,
  output logic [23:0] o_i2c_data,
  output logic        o_busy,
  output logic        o_done,
`ifdef WM_INIT_TIMEOUT_EN
  output logic        o_error,
`endif
  output logic [2:0]  o_cmd_idx
);

  localparam int GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST =
    GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [2:0] LAST_IDX = 3'(N_CMD - 1);

  state_e         state_q, state_d;
  logic           start_q, start_d;
  logic [23:0]    data_q, data_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [2:0]     idx_q, idx_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic           fin_q;
  logic           fin_edge;

`ifdef WM_INIT_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0]  wd_q, wd_d;
  logic           err_q, err_d;
`endif

  // Level from the sender may still be high from the previous run
  assign fin_edge = i_i2c_finished & ~fin_q;

  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    data_d  = data_q;
    busy_d  = busy_q;
    done_d  = done_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
`ifdef WM_INIT_TIMEOUT_EN
    wd_d    = wd_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          start_d = 1'b1;
          data_d  = CFG_ROM[0];
          idx_d   = 3'd0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          state_d = WAIT;
`ifdef WM_INIT_TIMEOUT_EN
          wd_d    = '0;
          err_d   = 1'b0;
`endif
        end
      end
      WAIT: begin
        if (fin_edge) begin
          if (idx_q == LAST_IDX) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else if (GAP_CYCLES == 0) begin
            idx_d   = idx_q + 3'd1;
            data_d  = CFG_ROM[idx_d];
            start_d = 1'b1;
`ifdef WM_INIT_TIMEOUT_EN
            wd_d    = '0;
`endif
          end else begin
            idx_d   = idx_q + 3'd1;
            gap_d   = '0;
            state_d = GAP;
          end
`ifdef WM_INIT_TIMEOUT_EN
        end else if (wd_q == TO_LAST) begin
          busy_d  = 1'b0;
          done_d  = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
`endif
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          data_d  = CFG_ROM[idx_q];
          start_d = 1'b1;
          state_d = WAIT;
`ifdef WM_INIT_TIMEOUT_EN
          wd_d    = '0;
`endif
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      data_q  <= 24'h0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      idx_q   <= 3'd0;
      gap_q   <= '0;
      fin_q   <= 1'b0;
`ifdef WM_INIT_TIMEOUT_EN
      wd_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      fin_q   <= i_i2c_finished;
`ifdef WM_INIT_TIMEOUT_EN
      wd_q    <= wd_d;
      err_q   <= err_d;
`endif
    end
  end

  assign o_i2c_start = start_q;
  assign o_i2c_data  = data_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_cmd_idx   = idx_q;
`ifdef WM_INIT_TIMEOUT_EN
  assign o_error     = err_q;
`endif

endmodule

// File: tb/tb_wm8731_init_seq.sv
// Scoreboard bench for wm8731_init_seq: two gap settings, sender model,
// stale-finished, busy-start, mid-run reset and optional watchdog cases.
module tb_wm8731_init_seq;

  localparam int GAP_A = 4;
  localparam int GAP_B = 0;

  typedef struct {
    int w;
    int i;
  } exp_t;

  localparam logic [23:0] WORDS [7] = '{
    24'h341E00, 24'h340815, 24'h340A00, 24'h340C00,
    24'h340E42, 24'h341019, 24'h341201
  };

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start [2];
  logic        fin   [2];
  logic        st    [2];
  logic [23:0] dat   [2];
  logic        busy  [2];
  logic        done  [2];
  logic [2:0]  idx   [2];

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;

  exp_t q_a[$];
  exp_t q_b[$];
  int   done_exp  [2];
  int   last_rise [2];
  int   dly       [2];
  logic snd_rst   [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef WM_INIT_TIMEOUT_EN
  logic        err [2];
  logic        start_t, st_t, busy_t, done_t, err_t;
  logic        fin_t;
  logic [23:0] dat_t;
  logic [2:0]  idx_t;
`endif

  wm8731_init_seq #(.GAP_CYCLES(GAP_A)) u_a (
    .i_clk(clk), .i_rst(rst),
    .i_start(start[0]), .i_i2c_finished(fin[0]),
    .o_i2c_start(st[0]), .o_i2c_data(dat[0]),
    .o_busy(busy[0]), .o_done(done[0]),
`ifdef WM_INIT_TIMEOUT_EN
    .o_error(err[0]),
`endif
    .o_cmd_idx(idx[0])
  );

  wm8731_init_seq #(.GAP_CYCLES(GAP_B)) u_b (
    .i_clk(clk), .i_rst(rst),
    .i_start(start[1]), .i_i2c_finished(fin[1]),
    .o_i2c_start(st[1]), .o_i2c_data(dat[1]),
    .o_busy(busy[1]), .o_done(done[1]),
`ifdef WM_INIT_TIMEOUT_EN
    .o_error(err[1]),
`endif
    .o_cmd_idx(idx[1])
  );

`ifdef WM_INIT_TIMEOUT_EN
  wm8731_init_seq #(.TIMEOUT_CYCLES(64)) u_t (
    .i_clk(clk), .i_rst(rst),
    .i_start(start_t), .i_i2c_finished(fin_t),
    .o_i2c_start(st_t), .o_i2c_data(dat_t),
    .o_busy(busy_t), .o_done(done_t),
    .o_error(err_t),
    .o_cmd_idx(idx_t)
  );
`endif

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_seq(input int i, input int n, input bit with_done);
    for (int k = 0; k < n; k++) begin
      exp_t e;
      e.w = int'(WORDS[k]);
      e.i = k;
      if (i == 0) q_a.push_back(e);
      else        q_b.push_back(e);
    end
    if (with_done) done_exp[i]++;
  endtask

  task automatic pulse(input logic [1:0] m);
    start[0] = m[0];
    start[1] = m[1];
    @(negedge clk);
    start[0] = 1'b0;
    start[1] = 1'b0;
  endtask

  task automatic wait_done(input int i);
    for (int k = 0; k < 3000; k++) begin
      if (done[i]) break;
      @(negedge clk);
    end
    if (!done[i]) chk("done_timeout", 0, 1);
  endtask

  task automatic wait_idx(input int i, input int v);
    for (int k = 0; k < 3000; k++) begin
      if (int'(idx[i]) == v) break;
      @(negedge clk);
    end
    if (int'(idx[i]) != v) chk("idx_timeout", int'(idx[i]), v);
  endtask

  // Sender model: finished drops dly cycles after start, rises 30 later
  initial begin
    int t [2];
    t[0] = -1;
    t[1] = -1;
    fin[0] = 1'b0;
    fin[1] = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (snd_rst[i]) begin
          t[i] = -1;
          fin[i] = 1'b0;
        end else begin
          if (st[i]) t[i] = 0;
          else if (t[i] >= 0) t[i]++;
          if (t[i] >= 0) begin
            if (t[i] == dly[i] - 1) fin[i] = 1'b0;
            if (t[i] == 30) begin
              fin[i] = 1'b1;
              last_rise[i] = cyc;
              t[i] = -1;
            end
          end
        end
      end
    end
  end

  // Monitor: pops expected words on start pulses and done events
  initial begin
    logic dp [2];
    exp_t e;
    bit   has;
    dp[0] = 1'b0;
    dp[1] = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (st[i]) begin
          has = (i == 0) ? (q_a.size() > 0) : (q_b.size() > 0);
          if (!has) begin
            chk("unexpected_start", int'(dat[i]), 0);
          end else begin
            e = (i == 0) ? q_a.pop_front() : q_b.pop_front();
            chk("word", int'(dat[i]), e.w);
            chk("cmd_idx", int'(idx[i]), e.i);
            chk("busy_on_start", int'(busy[i]), 1);
            if (e.i != 0)
              chk("gap", cyc - last_rise[i], ((i == 0) ? GAP_A : GAP_B) + 1);
          end
        end
        if (done[i] && !dp[i]) begin
          if (done_exp[i] == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            done_exp[i]--;
            chk("done_latency", cyc - last_rise[i], 1);
            chk("busy_fall", int'(busy[i]), 0);
          end
        end
        dp[i] = done[i];
      end
    end
  end

  initial begin
    start[0] = 1'b0;
    start[1] = 1'b0;
    done_exp[0] = 0;
    done_exp[1] = 0;
    last_rise[0] = 0;
    last_rise[1] = 0;
    dly[0] = 1;
    dly[1] = 1;
    snd_rst[0] = 1'b0;
    snd_rst[1] = 1'b0;
`ifdef WM_INIT_TIMEOUT_EN
    start_t = 1'b0;
    fin_t   = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_start", int'(st[0]), 0);
    chk("rst_data", int'(dat[0]), 0);
    chk("rst_busy", int'(busy[0]), 0);
    chk("rst_done", int'(done[0]), 0);
    chk("rst_idx", int'(idx[0]), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_start", int'(st[0]), 0);

    // normal run on both gap settings
    push_seq(0, 7, 1);
    push_seq(1, 7, 1);
    pulse(2'b11);
    wait_done(0);
    wait_done(1);
`ifdef WM_INIT_TIMEOUT_EN
    chk("no_error", int'(err[0]), 0);
`endif

    // stale finished level held high into the next run
    chk("stale_fin_high", int'(fin[0]), 1);
    dly[0] = 5;
    push_seq(0, 7, 1);
    pulse(2'b01);
    chk("done_cleared", int'(done[0]), 0);
    repeat (3) @(negedge clk);
    chk("stale_idx_hold", int'(idx[0]), 0);
    chk("stale_busy", int'(busy[0]), 1);
    wait_done(0);
    dly[0] = 1;

    // start while busy is ignored
    push_seq(0, 7, 1);
    pulse(2'b01);
    wait_idx(0, 3);
    pulse(2'b01);
    wait_done(0);
    repeat (60) @(negedge clk);
    chk("busy_start_q", q_a.size(), 0);

    // reset in the middle of word 2
    push_seq(0, 3, 0);
    pulse(2'b01);
    wait_idx(0, 2);
    repeat (5) @(negedge clk);
    chk("pre_rst_q", q_a.size(), 0);
    rst = 1'b1;
    snd_rst[0] = 1'b1;
    @(negedge clk);
    chk("mid_rst_start", int'(st[0]), 0);
    chk("mid_rst_data", int'(dat[0]), 0);
    chk("mid_rst_busy", int'(busy[0]), 0);
    chk("mid_rst_done", int'(done[0]), 0);
    chk("mid_rst_idx", int'(idx[0]), 0);
    rst = 1'b0;
    snd_rst[0] = 1'b0;
    @(negedge clk);
    chk("after_rst_start", int'(st[0]), 0);
    chk("after_rst_busy", int'(busy[0]), 0);
    repeat (40) @(negedge clk);
    push_seq(0, 7, 1);
    pulse(2'b01);
    wait_done(0);

`ifdef WM_INIT_TIMEOUT_EN
    start_t = 1'b1;
    @(negedge clk);
    start_t = 1'b0;
    repeat (63) @(negedge clk);
    chk("to_err_early", int'(err_t), 0);
    chk("to_busy_early", int'(busy_t), 1);
    @(negedge clk);
    chk("to_err", int'(err_t), 1);
    chk("to_busy", int'(busy_t), 0);
    chk("to_done", int'(done_t), 0);
`endif

    repeat (5) @(negedge clk);
    chk("end_q_a", q_a.size(), 0);
    chk("end_q_b", q_b.size(), 0);
    chk("end_done_a", done_exp[0], 0);
    chk("end_done_b", done_exp[1], 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
